// File: rtl/bpu_pkg.sv
// bpu_pkg: shared BTB entry type, saturating counter helpers and default sizes for the branch predictor.
package bpu_pkg;

    localparam int DEF_XLEN        = 32;
    localparam int DEF_BTB_ENTRIES = 64;
    localparam int DEF_PHT_ENTRIES = 256;
    localparam int DEF_CTR_BITS    = 2;
    localparam int DEF_GHR_LEN     = 8;
    localparam int MAX_XLEN        = 64;

    // Tag/target sized for the widest supported datapath; narrower builds zero-extend.
    typedef struct packed {
        logic                valid;
        logic                jal;
        logic [MAX_XLEN-1:0] tag;
        logic [MAX_XLEN-1:0] target;
    } btb_entry_t;

    function automatic int unsigned ctr_inc(input int unsigned c, input int unsigned bits);
        return (c == ((32'd1 << bits) - 32'd1)) ? c : c + 32'd1;
    endfunction

    function automatic int unsigned ctr_dec(input int unsigned c);
        return (c == 32'd0) ? c : c - 32'd1;
    endfunction

endpackage

// File: rtl/bpu_prio_enc.sv
// bpu_prio_enc: lowest-index priority encoder with any-hit flag.
module bpu_prio_enc #(
    parameter int N = 64
) (
    input  logic [N-1:0]         req_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) idx_o = req_i[i] ? ($clog2(N))'(i) : idx_o;
    end

    assign any_o = |req_i;

endmodule

// File: rtl/bpu_gshare.sv
// bpu_gshare: fully-associative BTB plus PHT direction predictor.
// Define BPU_GSHARE_EN for gshare indexing (PC xor global history); otherwise bimodal.
module bpu_gshare
    import bpu_pkg::*;
#(
    parameter int XLEN        = DEF_XLEN,
    parameter int BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter int PHT_ENTRIES = DEF_PHT_ENTRIES,
    parameter int CTR_BITS    = DEF_CTR_BITS,
    parameter int GHR_LEN     = DEF_GHR_LEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            is_jal_i,
    input  logic            is_cond_branch_i,
    input  logic [XLEN-1:0] dec_pc_i,
    input  logic            exe_is_branch_i,
    input  logic            exe_is_cond_i,
    input  logic [XLEN-1:0] exe_pc_i,
    input  logic            branch_taken_i,
    input  logic            branch_misprediction_i,
    input  logic [XLEN-1:0] branch_target_addr_i,
    output logic            branch_hit_o,
    output logic            branch_decision_o,
    output logic [XLEN-1:0] branch_target_addr_o
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int PW = $clog2(PHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] PHT_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    btb_entry_t            btb_q [BTB_ENTRIES];
    logic [CTR_BITS-1:0]   pht_q [PHT_ENTRIES];
    logic [CTR_BITS-1:0]   pht_d;
    logic [IW-1:0]         ptr_q, ptr_d, f_idx, e_idx, d_idx_unused;
    logic [PW-1:0]         fidx, d_pidx_q, e_pidx_q;
    logic [BTB_ENTRIES-1:0] f_match, d_match, e_match;
    logic d_vld_q, e_vld_q, f_any, d_any, e_any, alloc, tgt_upd, pht_upd;

    always_comb begin
        f_match = '0;
        d_match = '0;
        e_match = '0;
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            f_match[i] = btb_q[i].valid && btb_q[i].tag == MAX_XLEN'(pc_i) && pc_i != '0;
            d_match[i] = btb_q[i].valid && btb_q[i].tag == MAX_XLEN'(dec_pc_i);
            e_match[i] = btb_q[i].valid && btb_q[i].tag == MAX_XLEN'(exe_pc_i);
        end
    end

    bpu_prio_enc #(.N(BTB_ENTRIES)) u_fenc (.req_i(f_match), .idx_o(f_idx),        .any_o(f_any));
    bpu_prio_enc #(.N(BTB_ENTRIES)) u_denc (.req_i(d_match), .idx_o(d_idx_unused), .any_o(d_any));
    bpu_prio_enc #(.N(BTB_ENTRIES)) u_eenc (.req_i(e_match), .idx_o(e_idx),        .any_o(e_any));

`ifdef BPU_GSHARE_EN
    logic [GHR_LEN-1:0] ghr_q, ghr_d;
    assign ghr_d = GHR_LEN'({ghr_q, branch_taken_i});
    assign fidx  = pc_i[PW+1:2] ^ PW'(ghr_q);
    always_ff @(posedge clk_i) begin
        if (!rst_ni) ghr_q <= '0;
        else if (pht_upd) ghr_q <= ghr_d;
    end
`else
    assign fidx = pc_i[PW+1:2];
`endif

    assign alloc   = !stall_i && (is_cond_branch_i || is_jal_i) && !d_any;
    // An allocation overwriting the resolving entry wins over its target update.
    assign tgt_upd = !stall_i && exe_is_branch_i && branch_taken_i && e_any && !(alloc && ptr_q == e_idx);
    assign pht_upd = !stall_i && exe_is_branch_i && exe_is_cond_i && e_vld_q;
    assign pht_d   = branch_taken_i ? CTR_BITS'(ctr_inc(32'(pht_q[e_pidx_q]), CTR_BITS))
                                    : CTR_BITS'(ctr_dec(32'(pht_q[e_pidx_q])));
    assign ptr_d   = ptr_q + IW'(alloc);

    assign branch_hit_o         = f_any;
    assign branch_target_addr_o = f_any ? btb_q[f_idx].target[XLEN-1:0] : '0;
    assign branch_decision_o    = f_any && (btb_q[f_idx].jal || pht_q[fidx][CTR_BITS-1]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= '0;
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= PHT_INIT;
            ptr_q    <= '0;
            d_pidx_q <= '0;
            e_pidx_q <= '0;
            d_vld_q  <= 1'b0;
            e_vld_q  <= 1'b0;
        end else if (!stall_i) begin
            if (alloc) btb_q[ptr_q] <= '{valid: 1'b1, jal: is_jal_i, tag: MAX_XLEN'(dec_pc_i), target: '0};
            if (tgt_upd) btb_q[e_idx].target <= MAX_XLEN'(branch_target_addr_i);
            if (pht_upd) pht_q[e_pidx_q] <= pht_d;
            ptr_q    <= ptr_d;
            d_pidx_q <= fidx;
            e_pidx_q <= d_pidx_q;
            d_vld_q  <= !branch_misprediction_i;
            e_vld_q  <= !branch_misprediction_i && d_vld_q;
        end
    end

endmodule

// File: tb/tb_bpu_gshare.sv
// tb_bpu_gshare: directed checks of BTB allocation/update, PHT counters, pipeline and reset.
module tb_bpu_gshare;

    logic        clk_i = 1'b0;
    logic        rst_ni, stall_i, is_jal_i, is_cond_branch_i;
    logic        exe_is_branch_i, exe_is_cond_i, branch_taken_i, branch_misprediction_i;
    logic [31:0] pc_i, dec_pc_i, exe_pc_i, branch_target_addr_i, branch_target_addr_o;
    logic        branch_hit_o, branch_decision_o;
    int          errors = 0;
    int          checks = 0;
    int          exp_pht [256];
    int          gh = 0;

    always #5 clk_i = ~clk_i;

    bpu_gshare dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .pc_i(pc_i),
        .is_jal_i(is_jal_i), .is_cond_branch_i(is_cond_branch_i), .dec_pc_i(dec_pc_i),
        .exe_is_branch_i(exe_is_branch_i), .exe_is_cond_i(exe_is_cond_i), .exe_pc_i(exe_pc_i),
        .branch_taken_i(branch_taken_i), .branch_misprediction_i(branch_misprediction_i),
        .branch_target_addr_i(branch_target_addr_i), .branch_hit_o(branch_hit_o),
        .branch_decision_o(branch_decision_o), .branch_target_addr_o(branch_target_addr_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int fidx(input logic [31:0] pc);
`ifdef BPU_GSHARE_EN
        return int'(pc[9:2]) ^ gh;
`else
        return int'(pc[9:2]);
`endif
    endfunction

    task automatic idle();
        stall_i = 1'b0; pc_i = '0; is_jal_i = 1'b0; is_cond_branch_i = 1'b0; dec_pc_i = '0;
        exe_is_branch_i = 1'b0; exe_is_cond_i = 1'b0; exe_pc_i = '0; branch_taken_i = 1'b0;
        branch_misprediction_i = 1'b0; branch_target_addr_i = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0; stall_i = 1'b1; exe_is_branch_i = 1'b1; exe_is_cond_i = 1'b1;
        step();
        step();
        idle();
        rst_ni = 1'b1;
        for (int i = 0; i < 256; i++) exp_pht[i] = 1;
        gh = 0;
    endtask

    task automatic run_branch(input logic [31:0] pc, input logic jal, input logic taken,
                              input logic [31:0] tgt, input logic stall_exe);
        int idx;
        idle();
        pc_i = pc;
        idx = fidx(pc);
        step();
        pc_i = '0; is_cond_branch_i = !jal; is_jal_i = jal; dec_pc_i = pc;
        step();
        is_cond_branch_i = 1'b0; is_jal_i = 1'b0; dec_pc_i = '0;
        exe_is_branch_i = 1'b1; exe_is_cond_i = !jal; exe_pc_i = pc;
        branch_taken_i = taken; branch_target_addr_i = tgt;
        if (stall_exe) begin
            stall_i = 1'b1;
            step();
            chk("stall_pht", 64'(dut.pht_q[idx]), 64'(exp_pht[idx]));
            stall_i = 1'b0;
        end
        step();
        if (!jal) begin
            exp_pht[idx] = taken ? (exp_pht[idx] == 3 ? 3 : exp_pht[idx] + 1)
                                 : (exp_pht[idx] == 0 ? 0 : exp_pht[idx] - 1);
`ifdef BPU_GSHARE_EN
            gh = ((gh << 1) | int'(taken)) & 255;
`endif
            chk("pht_upd", 64'(dut.pht_q[idx]), 64'(exp_pht[idx]));
        end
        idle();
    endtask

    task automatic fetch_chk(input string tag, input logic [31:0] pc, input logic hit,
                             input logic [31:0] tgt, input logic jal);
        pc_i = pc;
        #1;
        chk({tag, "_hit"}, 64'(branch_hit_o), 64'(hit));
        chk({tag, "_tgt"}, 64'(branch_target_addr_o), 64'(tgt));
        chk({tag, "_dec"}, 64'(branch_decision_o), 64'(hit && (jal || ((exp_pht[fidx(pc)] >> 1) & 1) == 1)));
        pc_i = '0;
    endtask

    initial begin
        do_reset();
        fetch_chk("rst", 32'h100, 1'b0, 32'h0, 1'b0);
        chk("rst_ptr", 64'(dut.ptr_q), 64'h0);

        run_branch(32'h100, 1'b0, 1'b1, 32'h200, 1'b0);
        fetch_chk("cond", 32'h100, 1'b1, 32'h200, 1'b0);
`ifndef BPU_GSHARE_EN
        chk("cond_ctr", 64'(dut.pht_q[8'h40]), 64'd2);
`endif

        run_branch(32'h300, 1'b1, 1'b1, 32'h400, 1'b0);
        fetch_chk("jal", 32'h300, 1'b1, 32'h400, 1'b1);
        pc_i = 32'h300;
        #1;
        chk("jal_dec", 64'(branch_decision_o), 64'h1);
        pc_i = '0;

        for (int k = 0; k < 4; k++) run_branch(32'h608, 1'b0, 1'b1, 32'h700, 1'b0);
        run_branch(32'h608, 1'b0, 1'b0, 32'h700, 1'b0);
        fetch_chk("sat", 32'h608, 1'b1, 32'h700, 1'b0);
`ifndef BPU_GSHARE_EN
        chk("sat_ctr", 64'(dut.pht_q[8'h82]), 64'd2);
`endif
        run_branch(32'h608, 1'b0, 1'b1, 32'h710, 1'b1);
        fetch_chk("stall", 32'h608, 1'b1, 32'h710, 1'b0);

        branch_misprediction_i = 1'b1;
        step();
        chk("flush_dv", 64'(dut.d_vld_q), 64'h0);
        chk("flush_ev", 64'(dut.e_vld_q), 64'h0);
        idle();
        step();
        chk("refill_dv", 64'(dut.d_vld_q), 64'h1);

        do_reset();
        fetch_chk("rst2", 32'h608, 1'b0, 32'h0, 1'b0);
        run_branch(32'h700, 1'b0, 1'b1, 32'h780, 1'b0);
        run_branch(32'h700, 1'b0, 1'b1, 32'h780, 1'b0);
`ifdef BPU_GSHARE_EN
        chk("hist_c0", 64'(dut.pht_q[8'hC0]), 64'd2);
        chk("hist_c1", 64'(dut.pht_q[8'hC1]), 64'd2);
`else
        chk("hist_c0", 64'(dut.pht_q[8'hC0]), 64'd3);
        chk("hist_c1", 64'(dut.pht_q[8'hC1]), 64'd1);
`endif

        do_reset();
        for (int k = 0; k < 65; k++) begin
            is_cond_branch_i = 1'b1;
            dec_pc_i = 32'h1000 + 32'(4 * k);
            step();
        end
        idle();
        chk("wrap_ptr", 64'(dut.ptr_q), 64'h1);
        chk("wrap_tag0", dut.btb_q[0].tag, 64'h1100);
        fetch_chk("evicted", 32'h1000, 1'b0, 32'h0, 1'b0);
        fetch_chk("kept", 32'h1004, 1'b1, 32'h0, 1'b0);
        fetch_chk("newest", 32'h1100, 1'b1, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
